// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fetch/data arbiter in front of a single-port memory
// One transaction outstanding at a time; data wins unless a fetch has waited STARVE_LIM data grants.
module mem_arbiter #(
  parameter int unsigned STARVE_LIM = 4,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ack,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  localparam int unsigned SW = (STARVE_LIM < 8) ? 3 : $clog2(STARVE_LIM + 1);
  localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [SW-1:0] STREAK_MAX = SW'(STARVE_LIM);
  localparam logic [CW-1:0] WAIT_LAST  = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_BUSY_I = 2'd1,
    S_BUSY_D = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic          mem_req_q, mem_req_d;
  logic          mem_we_q, mem_we_d;
  logic [31:0]   mem_addr_q, mem_addr_d;
  logic [31:0]   mem_wdata_q, mem_wdata_d;
  logic          if_ack_q, if_ack_d;
  logic          d_ack_q, d_ack_d;
  logic          err_q, err_d;
  logic [31:0]   if_rdata_q, if_rdata_d;
  logic [31:0]   d_rdata_q, d_rdata_d;
  logic [SW-1:0] streak_q, streak_d;
  logic [CW-1:0] wait_q, wait_d;
  logic          fetch_first;

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    streak_d    = streak_q;
    wait_d      = wait_q;
    if_ack_d    = 1'b0;
    d_ack_d     = 1'b0;
    err_d       = 1'b0;
    fetch_first = if_req && (streak_q == STREAK_MAX);

    unique case (state_q)
      S_IDLE: begin
        // The ack cycle is a bubble for both requesters, so a held request cannot re-grant there.
        if (!if_ack_q && !d_ack_q) begin
          if (d_req && !fetch_first) begin
            state_d     = S_BUSY_D;
            mem_req_d   = 1'b1;
            mem_we_d    = d_we;
            mem_addr_d  = d_addr;
            mem_wdata_d = d_wdata;
            wait_d      = '0;
            if (if_req && (streak_q != STREAK_MAX)) begin
              streak_d = streak_q + 1'b1;
            end
          end else if (if_req) begin
            state_d     = S_BUSY_I;
            mem_req_d   = 1'b1;
            mem_we_d    = 1'b0;
            mem_addr_d  = if_addr;
            mem_wdata_d = '0;
            wait_d      = '0;
            streak_d    = '0;
          end
        end
      end
      S_BUSY_I, S_BUSY_D: begin
        if (mem_ack || (wait_q == WAIT_LAST)) begin
          state_d   = S_IDLE;
          mem_req_d = 1'b0;
          err_d     = !mem_ack;
          if (state_q == S_BUSY_I) begin
            if_ack_d = 1'b1;
            if (mem_ack) begin
              if_rdata_d = mem_rdata;
            end
          end else begin
            d_ack_d = 1'b1;
            if (mem_ack && !mem_we_q) begin
              d_rdata_d = mem_rdata;
            end
          end
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      default: begin
        state_d   = S_IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_ack_q    <= 1'b0;
      d_ack_q     <= 1'b0;
      err_q       <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      streak_q    <= '0;
      wait_q      <= '0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_ack_q    <= if_ack_d;
      d_ack_q     <= d_ack_d;
      err_q       <= err_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      streak_q    <= streak_d;
      wait_q      <= wait_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_ack    = if_ack_q;
  assign d_ack     = d_ack_q;
  assign err       = err_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;

endmodule
